// File: rtl/lcd_timing_gen.sv
// RGB565 LCD timing generator with built-in test patterns and a one-cycle-latency
// external pixel fetch port; a three-stage pipeline keeps syncs, DE and colour aligned.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 30,
  parameter int H_PW     = 10,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 5,
  parameter int V_PW     = 4,
  parameter int V_BP     = 20,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          PixelClk,
  input  logic          nRST,
  input  logic [1:0]    mode,
  output logic          pix_req,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  input  logic [15:0]   pix_data,
  output logic          frame_start,
  output logic          LCD_DE,
  output logic          LCD_HSYNC,
  output logic          LCD_VSYNC,
  output logic [4:0]    LCD_R,
  output logic [5:0]    LCD_G,
  output logic [4:0]    LCD_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_PW + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_PW + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_PW);
  localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_PW);

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic          active, hs_n, vs_n, frame_origin, grid_on;

  logic          pix_req_q, pix_req_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic          s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic [1:0]    mode_q, mode_d;
  logic [XW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;

  logic          s2_de_q, s2_de_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
  logic          s2_first_q, s2_first_d, s2_ext_q, s2_ext_d;
  logic [15:0]   s2_rgb_q, s2_rgb_d;

  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [15:0]   rgb_q, rgb_d;

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + XW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
    end

    active       = (h_q < H_ACT) && (v_q < V_ACT);
    hs_n         = !((h_q >= HS_START) && (h_q < HS_END));
    vs_n         = !((v_q >= VS_START) && (v_q < VS_END));
    frame_origin = (h_q == '0) && (v_q == '0);

    // Stage 1: fetch request; mode only changes at the frame origin so a frame never tears
    mode_d    = frame_origin ? mode : mode_q;
    pix_req_d = active;
    pix_x_d   = active ? h_q : pix_x_q;
    pix_y_d   = active ? v_q : pix_y_q;
    s1_hs_d   = hs_n;
    s1_vs_d   = vs_n;

    // Bar index tracks pix_x, stepping every BAR_W pixels and saturating at the last bar
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (active) begin
      if (h_q == '0) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + XW'(1);
      end
    end

    s2_de_d    = pix_req_q;
    s2_hs_d    = s1_hs_q;
    s2_vs_d    = s1_vs_q;
    s2_first_d = pix_req_q && (pix_x_q == '0) && (pix_y_q == '0);
    s2_ext_d   = (mode_q == 2'd3);
    grid_on    = (pix_x_q[3:0] == 4'd0) || (pix_y_q[3:0] == 4'd0) ||
                 (pix_x_q == X_LAST) || (pix_y_q == Y_LAST);
    case (mode_q)
      2'd0:    s2_rgb_d = {{5{bar_idx_q[2]}}, {6{bar_idx_q[1]}}, {5{bar_idx_q[0]}}};
      2'd1:    s2_rgb_d = {16{grid_on}};
      2'd2:    s2_rgb_d = {pix_x_q[7:3], pix_y_q[7:2],
                           5'((9'(pix_x_q) + 9'(pix_y_q)) >> 4)};
      default: s2_rgb_d = '0;
    endcase

    // Stage 3: external data arrives now, one cycle after its request
    de_d  = s2_de_q;
    hs_d  = s2_hs_q;
    vs_d  = s2_vs_q;
    fs_d  = s2_first_q;
    rgb_d = s2_de_q ? (s2_ext_q ? pix_data : s2_rgb_q) : '0;
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      h_q        <= '0;
      v_q        <= '0;
      pix_req_q  <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      mode_q     <= '0;
      bar_cnt_q  <= '0;
      bar_idx_q  <= '0;
      s2_de_q    <= 1'b0;
      s2_hs_q    <= 1'b1;
      s2_vs_q    <= 1'b1;
      s2_first_q <= 1'b0;
      s2_ext_q   <= 1'b0;
      s2_rgb_q   <= '0;
      de_q       <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      fs_q       <= 1'b0;
      rgb_q      <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      pix_req_q  <= pix_req_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      mode_q     <= mode_d;
      bar_cnt_q  <= bar_cnt_d;
      bar_idx_q  <= bar_idx_d;
      s2_de_q    <= s2_de_d;
      s2_hs_q    <= s2_hs_d;
      s2_vs_q    <= s2_vs_d;
      s2_first_q <= s2_first_d;
      s2_ext_q   <= s2_ext_d;
      s2_rgb_q   <= s2_rgb_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      fs_q       <= fs_d;
      rgb_q      <= rgb_d;
    end
  end

  assign pix_req     = pix_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;
  assign LCD_DE      = de_q;
  assign LCD_HSYNC   = hs_q;
  assign LCD_VSYNC   = vs_q;
  assign LCD_R       = rgb_q[15:11];
  assign LCD_G       = rgb_q[10:5];
  assign LCD_B       = rgb_q[4:0];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a reduced panel geometry: every cycle the outputs are
// compared with a model that derives timing and colour directly from the cycle index.
module tb_lcd_timing_gen;

  localparam int HA = 128, HFP = 4, HPW = 4, HBP = 8;
  localparam int VA = 44, VFP = 2, VPW = 3, VBP = 3;
  localparam int HT = HA + HFP + HPW + HBP;
  localparam int VT = VA + VFP + VPW + VBP;
  localparam int FRAME = HT * VT;
  localparam int BAR_W = HA / 8;
  localparam int XW = 10, YW = 9;
  localparam logic [39:0] RESET_VEC = {1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};

  logic          PixelClk = 1'b0;
  logic          nRST;
  logic [1:0]    mode;
  logic          pix_req;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [15:0]   pix_data;
  logic          frame_start, LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0]    LCD_R;
  logic [5:0]    LCD_G;
  logic [4:0]    LCD_B;

  int          checks = 0;
  int          failures = 0;
  int          k;
  logic [1:0]  frameMode [0:15];
  int          plan [0:7] = '{0, 1, 2, 3, 3, 0, 2, 1};
  int          expPixX, expPixY;
  logic [15:0] pendingData;
  int          deLine, vsLow, fsCount;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_PW(HPW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_PW(VPW), .V_BP(VBP),
    .XW(XW), .YW(YW)
  ) dut (
    .PixelClk(PixelClk), .nRST(nRST), .mode(mode),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC),
    .LCD_VSYNC(LCD_VSYNC), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
  );

  always #5 PixelClk = ~PixelClk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not complete (failures so far %0d)", failures);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] observed();
    return {pix_req, pix_x, pix_y, frame_start, LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B};
  endfunction

  function automatic bit isActive(int c);
    return ((c % HT) < HA) && (((c / HT) % VT) < VA);
  endfunction

  function automatic logic [15:0] bramWord(int x, int y);
    return {5'(x), 6'(y), 5'(x)};
  endfunction

  function automatic logic [15:0] colourOf(logic [1:0] md, int x, int y);
    int b;
    case (md)
      2'd0: begin
        b = x / BAR_W;
        if (b > 7) b = 7;
        return {((b & 4) != 0) ? 5'd31 : 5'd0, ((b & 2) != 0) ? 6'd63 : 6'd0,
                ((b & 1) != 0) ? 5'd31 : 5'd0};
      end
      2'd1: return ((x % 16 == 0) || (y % 16 == 0) || (x == HA - 1) || (y == VA - 1)) ?
                   16'hFFFF : 16'h0000;
      2'd2: return {5'(x / 8), 6'(y / 4), 5'(((x + y) % 512) / 16)};
      default: return bramWord(x, y);
    endcase
  endfunction

  // Mode follows a plan per frame with random mid-frame changes that must not take effect
  task automatic applyStimulus(input bit scramble);
    int pos;
    logic [15:0] nextData;
    pos = k % FRAME;
    if (pos == FRAME - 100) mode = 2'(plan[k / FRAME + 1]);
    else if (scramble && pos < FRAME - 100 && $urandom_range(0, 299) == 0)
      mode = 2'($urandom_range(0, 3));
    nextData    = pix_req ? bramWord(int'(pix_x), int'(pix_y)) : 16'($urandom);
    pix_data    = pendingData;
    pendingData = nextData;
  endtask

  task automatic runCycles(input int n, input bit scramble);
    int c1, c3, h3, v3;
    logic de, hsn, vsn, fs;
    logic [15:0] rgb;
    logic [39:0] exp;
    for (int i = 0; i < n; i++) begin
      @(posedge PixelClk);
      k++;
      if ((k - 1) % FRAME == 0) frameMode[((k - 1) / FRAME) % 16] = mode;
      @(negedge PixelClk);
      c1 = k - 1;
      if (isActive(c1)) begin
        expPixX = c1 % HT;
        expPixY = (c1 / HT) % VT;
      end
      c3 = k - 3;
      if (c3 < 0) begin
        de = 0; hsn = 1; vsn = 1; fs = 0; rgb = '0;
      end else begin
        h3  = c3 % HT;
        v3  = (c3 / HT) % VT;
        de  = isActive(c3);
        hsn = !(h3 >= HA + HFP && h3 < HA + HFP + HPW);
        vsn = !(v3 >= VA + VFP && v3 < VA + VFP + VPW);
        fs  = de && h3 == 0 && v3 == 0;
        rgb = de ? colourOf(frameMode[(c3 / FRAME) % 16], h3, v3) : 16'h0000;
      end
      exp = {isActive(c1), XW'(expPixX), YW'(expPixY), fs, de, hsn, vsn, rgb};
      checkOutput($sformatf("cycle%0d", k), observed(), exp);
      if (c3 >= 0 && c3 < HT && LCD_DE) deLine++;
      if (c3 >= 0 && c3 < FRAME && !LCD_VSYNC) vsLow++;
      if (frame_start) fsCount++;
      applyStimulus(scramble);
    end
  endtask

  task automatic restartModel();
    k = 0; expPixX = 0; expPixY = 0; pendingData = '0;
    deLine = 0; vsLow = 0; fsCount = 0;
    mode = 2'(plan[0]);
  endtask

  initial begin
    nRST = 1'b0;
    pix_data = '0;
    restartModel();
    repeat (3) @(negedge PixelClk);
    checkOutput("reset_state", observed(), RESET_VEC);

    nRST = 1'b1;
    runCycles(5 * FRAME + 100, 1'b1);
    checkOutput("de_per_line", 40'(deLine), 40'(HA));
    checkOutput("vsync_low_cycles", 40'(vsLow), 40'(VPW * HT));
    checkOutput("frame_start_count", 40'(fsCount), 40'((5 * FRAME + 100 - 3) / FRAME + 1));

    runCycles(30 * HT + 50, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("async_reset", observed(), RESET_VEC);
    for (int i = 0; i < 3; i++) begin
      @(negedge PixelClk);
      checkOutput($sformatf("reset_held%0d", i), observed(), RESET_VEC);
    end

    restartModel();
    nRST = 1'b1;
    runCycles(FRAME + 2 * HT, 1'b0);
    checkOutput("restart_de_per_line", 40'(deLine), 40'(HA));
    checkOutput("restart_vsync_low", 40'(vsLow), 40'(VPW * HT));
    checkOutput("restart_frame_starts", 40'(fsCount), 40'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
